// File: rtl/prog_loader.sv
// Boot loader: streams bytes into extmem, optionally read-back checksums them, then hands the bus to the core.
// Latency: 3 cycles per byte (LOAD/SETUP/WRITE); last accept to cpu_reset low = 2 + load_count + 2 cycles with VERIFY.
// Backpressure: in_ready is high only in LOAD; 64-byte capacity, after which the stream is never accepted again.
//
// Ports:
//   clk, reset (async, active-low)
//   in_data/in_valid/in_last/in_ready : program byte stream
//   cpu_mem_* : core memory bus, passed through to mem_* only in RUN
//   mem_*     : extmem bus (mem_dout is combinational read data)
//   cpu_reset : reset to the core, released one cycle after RUN is entered
//   done, verify_err, load_count : status
module prog_loader #(
    parameter logic [5:0] BASE_ADDR = 6'd0,
    parameter bit         VERIFY    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    input  logic [7:0] cpu_mem_din,
    input  logic [5:0] cpu_mem_addr,
    input  logic       cpu_mem_read,
    input  logic       cpu_mem_write,
    output logic [7:0] cpu_mem_dout,
    output logic [7:0] mem_din,
    output logic [5:0] mem_addr,
    output logic       mem_read,
    output logic       mem_write,
    input  logic [7:0] mem_dout,
    output logic       cpu_reset,
    output logic       done,
    output logic       verify_err,
    output logic [6:0] load_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_WRITE,
        S_VRD,
        S_VCHK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [6:0] count_q;
    logic [6:0] rd_idx;
    logic [7:0] sum_wr;
    logic [7:0] sum_rd;
    logic       last_flag;
    logic [5:0] addr_q;
    logic [7:0] din_q;
    logic       cpu_reset_q;
    logic       run;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  next_state = S_LOAD;
            S_LOAD:  if (in_valid) next_state = S_SETUP;
            S_SETUP: next_state = S_WRITE;
            S_WRITE: begin
                if (!last_flag) begin
                    next_state = S_LOAD;
                end else if (VERIFY) begin
                    next_state = S_VRD;
                end else begin
                    next_state = S_RUN;
                end
            end
            // count_q already includes the final byte here, so it is >= 1
            S_VRD:   if (rd_idx == count_q - 7'd1) next_state = S_VCHK;
            S_VCHK:  next_state = (sum_rd == sum_wr) ? S_RUN : S_ERROR;
            S_RUN:   next_state = S_RUN;
            S_ERROR: next_state = S_ERROR;
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: write address/data are captured at accept and held through
    // SETUP and WRITE so they are stable for the whole strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= 7'd0;
            rd_idx      <= 7'd0;
            sum_wr      <= 8'd0;
            sum_rd      <= 8'd0;
            last_flag   <= 1'b0;
            addr_q      <= BASE_ADDR;
            din_q       <= 8'd0;
            cpu_reset_q <= 1'b1;
        end else begin
            // Core reset drops on the cycle after RUN is entered
            cpu_reset_q <= (state != S_RUN);
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        din_q     <= in_data;
                        addr_q    <= BASE_ADDR + count_q[5:0];
                        sum_wr    <= sum_wr + in_data;
                        // The 64th byte ends the program regardless of in_last
                        last_flag <= in_last || (count_q == 7'd63);
                    end
                end
                S_WRITE: begin
                    count_q <= count_q + 7'd1;
                    if (last_flag) begin
                        addr_q <= BASE_ADDR;
                        rd_idx <= 7'd0;
                    end
                end
                S_VRD: begin
                    sum_rd <= sum_rd + mem_dout;
                    rd_idx <= rd_idx + 7'd1;
                    addr_q <= addr_q + 6'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign run = (state == S_RUN);

    // In RUN the loader is a transparent wire between core and extmem
    assign mem_addr     = run ? cpu_mem_addr  : addr_q;
    assign mem_din      = run ? cpu_mem_din   : din_q;
    assign mem_read     = run ? cpu_mem_read  : (state == S_VRD);
    assign mem_write    = run ? cpu_mem_write : (state == S_WRITE);
    assign cpu_mem_dout = run ? mem_dout      : 8'd0;

    assign in_ready   = (state == S_LOAD);
    assign done       = run || (state == S_ERROR);
    assign verify_err = (state == S_ERROR);
    assign cpu_reset  = cpu_reset_q;
    assign load_count = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: dut0 (BASE 0, verify on) and dut1 (BASE 3E, verify off)
// share the stream and core inputs, each with its own extmem model.
// dut0's extmem can corrupt bit0 of reads from address 2.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic [7:0] cpu_mem_din = 8'd0;
    logic [5:0] cpu_mem_addr = 6'd0;
    logic       cpu_mem_read = 1'b0;
    logic       cpu_mem_write = 1'b0;

    logic       in_ready0, in_ready1;
    logic [7:0] cpu_mem_dout0, cpu_mem_dout1;
    logic [7:0] mem_din0, mem_din1;
    logic [5:0] mem_addr0, mem_addr1;
    logic       mem_read0, mem_read1;
    logic       mem_write0, mem_write1;
    logic [7:0] mem_dout0, mem_dout1;
    logic       cpu_reset0, cpu_reset1;
    logic       done0, done1;
    logic       verify_err0, verify_err1;
    logic [6:0] load_count0, load_count1;

    logic [7:0] mem0 [0:63];
    logic [7:0] mem1 [0:63];
    logic       corrupt = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_cyc = 0;
    logic [7:0] pb [0:69];

    // write-stream monitor state
    logic       mon_en = 1'b0;
    int         mon_checks = 0;
    int         mon_fails = 0;
    logic       prev_we = 1'b0;
    logic       prev_rdy = 1'b0;
    logic [5:0] prev_addr = 6'd0;
    logic [7:0] prev_din = 8'd0;
    logic [7:0] wr_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prog_loader #(.BASE_ADDR(6'h00), .VERIFY(1'b1)) dut0 (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready0),
        .cpu_mem_din(cpu_mem_din), .cpu_mem_addr(cpu_mem_addr),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write), .cpu_mem_dout(cpu_mem_dout0),
        .mem_din(mem_din0), .mem_addr(mem_addr0), .mem_read(mem_read0), .mem_write(mem_write0),
        .mem_dout(mem_dout0), .cpu_reset(cpu_reset0), .done(done0),
        .verify_err(verify_err0), .load_count(load_count0)
    );

    prog_loader #(.BASE_ADDR(6'h3E), .VERIFY(1'b0)) dut1 (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready1),
        .cpu_mem_din(cpu_mem_din), .cpu_mem_addr(cpu_mem_addr),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write), .cpu_mem_dout(cpu_mem_dout1),
        .mem_din(mem_din1), .mem_addr(mem_addr1), .mem_read(mem_read1), .mem_write(mem_write1),
        .mem_dout(mem_dout1), .cpu_reset(cpu_reset1), .done(done1),
        .verify_err(verify_err1), .load_count(load_count1)
    );

    // extmem models
    always @(posedge clk) begin
        if (mem_write0) mem0[mem_addr0] <= mem_din0;
        if (mem_write1) mem1[mem_addr1] <= mem_din1;
    end
    assign mem_dout0 = mem_read0 ? (mem0[mem_addr0] | {7'd0, corrupt && (mem_addr0 == 6'd2)}) : 8'h00;
    assign mem_dout1 = mem_read1 ? mem1[mem_addr1] : 8'h00;

    // Every write strobe must follow a quiet cycle with identical addr/data
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_write0) begin
                mon_checks++;
                if (prev_we || prev_rdy || prev_addr !== mem_addr0 || prev_din !== mem_din0) begin
                    mon_fails++;
                    $display("FAIL setup_before_write: addr %h din %h prev_addr %h prev_din %h prev_we %b prev_rdy %b",
                             mem_addr0, mem_din0, prev_addr, prev_din, prev_we, prev_rdy);
                end
                wr_q.push_back(mem_din0);
            end
            if (in_ready0 && (mem_write0 || mem_read0)) begin
                mon_fails++;
                $display("FAIL ready_outside_load: in_ready=1 with write=%b read=%b", mem_write0, mem_read0);
            end
        end
        prev_we   = mem_write0;
        prev_rdy  = in_ready0;
        prev_addr = mem_addr0;
        prev_din  = mem_din0;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0;
        cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; cpu_mem_addr = 6'd0; cpu_mem_din = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Streams pb[0..n-1]; in_valid random when rnd. Returns number accepted.
    task automatic send_prog(input int n, input bit rnd, input int last_idx, output int acc);
        int i;
        int budget;
        logic v;
        i = 0; budget = 0; acc = 0;
        while (i < n && budget < 400) begin
            @(negedge clk);
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = v;
            if (v) begin
                in_data = pb[i];
                in_last = (i == last_idx);
            end else begin
                in_data = 8'hFF;   // garbage plus in_last must be ignored
                in_last = 1'b1;
            end
            if (v && in_ready0) begin
                @(posedge clk);
                #1;
                hs_cyc = cyc;
                i++;
                acc++;
            end
            budget++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done0(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b1;
        cpu_mem_read = 1'b1;
        #1;
        checks++; if (cpu_reset0 !== 1'b1) begin failures++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset0); end
        checks++; if (done0 !== 1'b0 || verify_err0 !== 1'b0) begin failures++; $display("FAIL rst_status: done %b err %b want 0 0", done0, verify_err0); end
        checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b want 0", in_ready0); end
        checks++; if (load_count0 !== 7'd0) begin failures++; $display("FAIL rst_load_count: got %0d want 0", load_count0); end
        checks++; if (mem_write0 !== 1'b0 || mem_read0 !== 1'b0) begin failures++; $display("FAIL rst_strobes: wr %b rd %b want 0 0", mem_write0, mem_read0); end
        checks++; if (mem_addr0 !== 6'h00 || mem_din0 !== 8'h00) begin failures++; $display("FAIL rst_bus0: addr %h din %h want 00 00", mem_addr0, mem_din0); end
        checks++; if (mem_addr1 !== 6'h3E) begin failures++; $display("FAIL rst_base1: addr %h want 3e", mem_addr1); end
        checks++; if (cpu_mem_dout0 !== 8'h00) begin failures++; $display("FAIL rst_cpu_dout: got %h want 00", cpu_mem_dout0); end
        in_valid = 1'b0;
        cpu_mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL idle_in_ready: got %b want 0", in_ready0); end
        @(posedge clk);
        #1;
        checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL load_in_ready: got %b want 1", in_ready0); end
    endtask

    task automatic test_basic();
        int acc;
        int t0;
        int t1;
        do_reset();
        pb[0] = 8'hD0; pb[1] = 8'hAA; pb[2] = 8'h55;
        send_prog(3, 1'b0, 2, acc);
        t0 = -1; t1 = -1;
        for (int k = 0; k < 100; k++) begin
            if (t0 < 0 && !cpu_reset0) t0 = cyc - hs_cyc;
            if (t1 < 0 && !cpu_reset1) t1 = cyc - hs_cyc;
            if (t0 >= 0 && t1 >= 0) break;
            @(negedge clk);
        end
        checks++; if (acc != 3) begin failures++; $display("FAIL basic_accepted: got %0d want 3", acc); end
        checks++; if (mem0[0] !== 8'hD0 || mem0[1] !== 8'hAA || mem0[2] !== 8'h55) begin
            failures++; $display("FAIL basic_mem: got %h %h %h want d0 aa 55", mem0[0], mem0[1], mem0[2]); end
        checks++; if (load_count0 !== 7'd3) begin failures++; $display("FAIL basic_load_count: got %0d want 3", load_count0); end
        checks++; if (done0 !== 1'b1 || verify_err0 !== 1'b0) begin failures++; $display("FAIL basic_status: done %b err %b want 1 0", done0, verify_err0); end
        checks++; if (t0 != 7) begin failures++; $display("FAIL basic_release_latency: got %0d want 7", t0); end
        checks++; if (t1 != 3) begin failures++; $display("FAIL noverify_release_latency: got %0d want 3", t1); end
        checks++; if (mem1[6'h3E] !== 8'hD0 || mem1[6'h3F] !== 8'hAA || mem1[6'h00] !== 8'h55) begin
            failures++; $display("FAIL noverify_mem: got %h %h %h want d0 aa 55", mem1[6'h3E], mem1[6'h3F], mem1[6'h00]); end
        checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL run_in_ready: got %b want 0", in_ready0); end
    endtask

    task automatic test_run_bus();
        @(negedge clk);
        cpu_mem_addr = 6'h01;
        cpu_mem_read = 1'b1;
        #1;
        checks++; if (mem_addr0 !== 6'h01 || mem_read0 !== 1'b1) begin failures++; $display("FAIL run_read_bus: addr %h rd %b want 01 1", mem_addr0, mem_read0); end
        checks++; if (cpu_mem_dout0 !== 8'hAA) begin failures++; $display("FAIL run_read_data: got %h want aa", cpu_mem_dout0); end
        @(negedge clk);
        cpu_mem_read = 1'b0;
        cpu_mem_write = 1'b1;
        cpu_mem_addr = 6'h03;
        cpu_mem_din = 8'h3C;
        #1;
        checks++; if (mem_write0 !== 1'b1 || mem_addr0 !== 6'h03 || mem_din0 !== 8'h3C) begin
            failures++; $display("FAIL run_write_bus: wr %b addr %h din %h want 1 03 3c", mem_write0, mem_addr0, mem_din0); end
        @(posedge clk);
        #1;
        cpu_mem_write = 1'b0;
        checks++; if (mem0[3] !== 8'h3C) begin failures++; $display("FAIL run_write_mem: got %h want 3c", mem0[3]); end
    endtask

    task automatic test_random_valid();
        int acc;
        bit ok;
        logic [7:0] exp [0:4];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44; exp[4] = 8'h55;
        do_reset();
        for (int k = 0; k < 5; k++) pb[k] = exp[k];
        wr_q.delete();
        mon_en = 1'b1;
        send_prog(5, 1'b1, 4, acc);
        wait_done0(ok);
        mon_en = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL rand_done_timeout: done %b want 1", done0); end
        checks += mon_checks;
        failures += mon_fails;
        checks++; if (wr_q.size() != 5) begin failures++; $display("FAIL rand_write_count: got %0d want 5", wr_q.size()); end
        for (int k = 0; k < 5 && k < wr_q.size(); k++) begin
            checks++; if (wr_q[k] !== exp[k]) begin failures++; $display("FAIL rand_write_order[%0d]: got %h want %h", k, wr_q[k], exp[k]); end
        end
        checks++; if (load_count0 !== 7'd5 || verify_err0 !== 1'b0) begin
            failures++; $display("FAIL rand_status: count %0d err %b want 5 0", load_count0, verify_err0); end
        checks++; if (mem0[4] !== 8'h55) begin failures++; $display("FAIL rand_mem4: got %h want 55", mem0[4]); end
    endtask

    task automatic test_capacity_wrap();
        int acc;
        do_reset();
        for (int k = 0; k < 70; k++) pb[k] = 8'(k);
        send_prog(70, 1'b0, -1, acc);
        checks++; if (acc != 64) begin failures++; $display("FAIL cap_accepted: got %0d want 64", acc); end
        checks++; if (load_count1 !== 7'd64 || load_count0 !== 7'd64) begin
            failures++; $display("FAIL cap_load_count: got %0d/%0d want 64", load_count1, load_count0); end
        checks++; if (mem1[6'h3E] !== 8'h00 || mem1[6'h3F] !== 8'h01) begin
            failures++; $display("FAIL cap_wrap_top: got %h %h want 00 01", mem1[6'h3E], mem1[6'h3F]); end
        checks++; if (mem1[6'h00] !== 8'h02 || mem1[6'h3D] !== 8'h3F) begin
            failures++; $display("FAIL cap_wrap_low: got %h %h want 02 3f", mem1[6'h00], mem1[6'h3D]); end
        checks++; if (done1 !== 1'b1 || in_ready1 !== 1'b0) begin failures++; $display("FAIL cap_done: done %b rdy %b want 1 0", done1, in_ready1); end
        checks++; if (done0 !== 1'b1 || verify_err0 !== 1'b0 || mem0[63] !== 8'h3F) begin
            failures++; $display("FAIL cap_verify_full: done %b err %b mem63 %h want 1 0 3f", done0, verify_err0, mem0[63]); end
    endtask

    task automatic test_verify_err();
        int acc;
        bit ok;
        do_reset();
        corrupt = 1'b1;
        pb[0] = 8'h01; pb[1] = 8'h02; pb[2] = 8'h54;
        send_prog(3, 1'b0, 2, acc);
        wait_done0(ok);
        repeat (3) @(negedge clk);
        cpu_mem_write = 1'b1;
        cpu_mem_read = 1'b1;
        cpu_mem_addr = 6'h02;
        #1;
        checks++; if (!ok) begin failures++; $display("FAIL err_done_timeout: done %b want 1", done0); end
        checks++; if (verify_err0 !== 1'b1 || done0 !== 1'b1) begin failures++; $display("FAIL err_status: err %b done %b want 1 1", verify_err0, done0); end
        checks++; if (cpu_reset0 !== 1'b1) begin failures++; $display("FAIL err_cpu_reset: got %b want 1", cpu_reset0); end
        checks++; if (mem_read0 !== 1'b0 || mem_write0 !== 1'b0) begin failures++; $display("FAIL err_bus_idle: rd %b wr %b want 0 0", mem_read0, mem_write0); end
        checks++; if (cpu_mem_dout0 !== 8'h00) begin failures++; $display("FAIL err_cpu_dout: got %h want 00", cpu_mem_dout0); end
        checks++; if (mem0[2] !== 8'h54) begin failures++; $display("FAIL err_mem2: got %h want 54", mem0[2]); end
        cpu_mem_write = 1'b0;
        cpu_mem_read = 1'b0;
        corrupt = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        int acc;
        bit ok;
        do_reset();
        pb[0] = 8'hA1; pb[1] = 8'hA2;
        send_prog(2, 1'b0, -1, acc);
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (load_count0 !== 7'd2 || mem0[1] !== 8'hA2) begin
            failures++; $display("FAIL mid_before_reset: count %0d mem1 %h want 2 a2", load_count0, mem0[1]); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (load_count0 !== 7'd0 || in_ready0 !== 1'b0 || cpu_reset0 !== 1'b1) begin
            failures++; $display("FAIL mid_reset_state: count %0d rdy %b cpu_rst %b want 0 0 1", load_count0, in_ready0, cpu_reset0); end
        checks++; if (mem_addr0 !== 6'h00 || mem_din0 !== 8'h00 || mem_write0 !== 1'b0) begin
            failures++; $display("FAIL mid_reset_bus: addr %h din %h wr %b want 00 00 0", mem_addr0, mem_din0, mem_write0); end
        @(negedge clk);
        reset = 1'b1;
        pb[0] = 8'hB1;
        send_prog(1, 1'b0, 0, acc);
        wait_done0(ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_done_timeout: done %b want 1", done0); end
        checks++; if (mem0[0] !== 8'hB1 || load_count0 !== 7'd1 || verify_err0 !== 1'b0) begin
            failures++; $display("FAIL mid_restart: mem0 %h count %0d err %b want b1 1 0", mem0[0], load_count0, verify_err0); end
        checks++; if (mem0[1] !== 8'hA2) begin failures++; $display("FAIL mid_mem_kept: got %h want a2", mem0[1]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_run_bus();
        test_random_valid();
        test_capacity_wrap();
        test_verify_err();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
